// File: rtl/write_addr_seq.sv
// Write-address sequencer: rewrites the WRITE block's fixed address into a strided
// multi-iteration address sequence and registers each write toward block RAM.
module write_addr_seq #(
   parameter int GROUP_SIZE      = 4,
   parameter int OUT_DATA_WIDTH  = 4,
   parameter int LOG_MAX_ADDRESS = 16,
   parameter int LOG_MAX_ITERS   = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 configure,
   input  logic [LOG_MAX_ADDRESS-1:0]           base_address,
   input  logic [LOG_MAX_ADDRESS-1:0]           writes_per_iter,
   input  logic [LOG_MAX_ITERS-1:0]             num_iters,
   input  logic [LOG_MAX_ADDRESS-1:0]           iter_stride,
   input  logic [GROUP_SIZE*OUT_DATA_WIDTH-1:0] data_in,
   input  logic                                 valid_in,
   output logic [GROUP_SIZE*OUT_DATA_WIDTH-1:0] data_out,
   output logic [LOG_MAX_ADDRESS-1:0]           address_out,
   output logic                                 valid_out,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err
);

   localparam int DW = GROUP_SIZE * OUT_DATA_WIDTH;
   localparam int AW = LOG_MAX_ADDRESS;
   localparam int IW = LOG_MAX_ITERS;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wpi_q, wpi_d;
   logic [IW-1:0]   iters_q, iters_d;
   logic [AW-1:0]   stride_q, stride_d;
   logic [AW-1:0]   wcnt_q, wcnt_d;
   logic [IW-1:0]   icnt_q, icnt_d;
   logic [AW-1:0]   iter_base_q, iter_base_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_out_q, data_out_d;
   logic [AW-1:0]   addr_out_q, addr_out_d;
   logic            valid_out_q, valid_out_d;
   logic            err_q, err_d;

   logic [AW-1:0]   next_base;
   logic            last_in_iter;
   logic            last_iter;

   assign next_base    = iter_base_q + stride_q;
   assign last_in_iter = (wcnt_q == wpi_q - AW'(1));
   assign last_iter    = (icnt_q == iters_q - IW'(1));

   always_comb begin
      state_d     = state_q;
      wpi_d       = wpi_q;
      iters_d     = iters_q;
      stride_d    = stride_q;
      wcnt_d      = wcnt_q;
      icnt_d      = icnt_q;
      iter_base_d = iter_base_q;
      addr_d      = addr_q;
      data_out_d  = data_out_q;
      addr_out_d  = addr_out_q;
      valid_out_d = 1'b0;
      err_d       = err_q;

      // configure has priority; a write colliding with it is always dropped
      if (configure) begin
         wpi_d       = writes_per_iter;
         iters_d     = num_iters;
         stride_d    = iter_stride;
         wcnt_d      = '0;
         icnt_d      = '0;
         iter_base_d = base_address;
         addr_d      = base_address;
         state_d     = (writes_per_iter == '0 || num_iters == '0) ? DONE : RUN;
         if (valid_in) err_d = 1'b1;
      end else if (valid_in) begin
         if (state_q == RUN) begin
            valid_out_d = 1'b1;
            addr_out_d  = addr_q;
            data_out_d  = data_in;
            if (!last_in_iter) begin
               wcnt_d = wcnt_q + AW'(1);
               addr_d = addr_q + AW'(1);
            end else begin
               wcnt_d      = '0;
               icnt_d      = icnt_q + IW'(1);
               iter_base_d = next_base;
               addr_d      = next_base;
               if (last_iter) state_d = DONE;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wpi_q       <= '0;
         iters_q     <= '0;
         stride_q    <= '0;
         wcnt_q      <= '0;
         icnt_q      <= '0;
         iter_base_q <= '0;
         addr_q      <= '0;
         data_out_q  <= '0;
         addr_out_q  <= '0;
         valid_out_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wpi_q       <= wpi_d;
         iters_q     <= iters_d;
         stride_q    <= stride_d;
         wcnt_q      <= wcnt_d;
         icnt_q      <= icnt_d;
         iter_base_q <= iter_base_d;
         addr_q      <= addr_d;
         data_out_q  <= data_out_d;
         addr_out_q  <= addr_out_d;
         valid_out_q <= valid_out_d;
         err_q       <= err_d;
      end
   end

   assign data_out    = data_out_q;
   assign address_out = addr_out_q;
   assign valid_out   = valid_out_q;
   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign err         = err_q;

endmodule

// File: tb/tb_write_addr_seq.sv
// Directed bench for write_addr_seq: hand-computed address/data/status vectors.
module tb_write_addr_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        configure = 1'b0;
   logic [15:0] base_address = '0;
   logic [15:0] writes_per_iter = '0;
   logic [15:0] num_iters = '0;
   logic [15:0] iter_stride = '0;
   logic [15:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic [15:0] data_out;
   logic [15:0] address_out;
   logic        valid_out;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   write_addr_seq #(
      .GROUP_SIZE(4), .OUT_DATA_WIDTH(4), .LOG_MAX_ADDRESS(16), .LOG_MAX_ITERS(16)
   ) dut (
      .clk(clk), .rst(rst), .configure(configure),
      .base_address(base_address), .writes_per_iter(writes_per_iter),
      .num_iters(num_iters), .iter_stride(iter_stride),
      .data_in(data_in), .valid_in(valid_in),
      .data_out(data_out), .address_out(address_out), .valid_out(valid_out),
      .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_job(input logic [15:0] b, input logic [15:0] w,
                          input logic [15:0] n, input logic [15:0] s);
      base_address = b; writes_per_iter = w; num_iters = n; iter_stride = s;
   endtask

   // one clock: drive, clock edge, then sample 1 time unit later
   task automatic step(input logic cfg, input logic v, input logic [15:0] d);
      configure = cfg; valid_in = v; data_in = d;
      @(posedge clk);
      #1;
      configure = 1'b0; valid_in = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [15:0] a,
                              input logic [15:0] d, input logic dn);
      $display("write %s addr=%04h data=%04h valid=%0b done=%0b", tag, address_out, data_out, valid_out, done);
      check({tag, "_valid"}, 32'(valid_out), 32'(1));
      check({tag, "_addr"},  32'(address_out), 32'(a));
      check({tag, "_data"},  32'(data_out), 32'(d));
      check({tag, "_done"},  32'(done), 32'(dn));
   endtask

   logic [15:0] exp1 [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                             16'h0110, 16'h0111, 16'h0112, 16'h0113};
   logic [15:0] exp3 [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

   initial begin
      // reset state
      #12;
      check("rst_valid", 32'(valid_out), 32'(0));
      check("rst_busy",  32'(busy), 32'(0));
      check("rst_done",  32'(done), 32'(0));
      check("rst_err",   32'(err), 32'(0));
      check("rst_addr",  32'(address_out), 32'(0));
      check("rst_data",  32'(data_out), 32'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      step(1'b0, 1'b0, 16'h0);

      // job 1: back-to-back writes
      set_job(16'h0100, 16'd4, 16'd2, 16'h0010);
      step(1'b1, 1'b0, 16'h0);
      check("j1_busy", 32'(busy), 32'(1));
      check("j1_done0", 32'(done), 32'(0));
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 16'hA000 + 16'(i));
         check_write($sformatf("j1_w%0d", i), exp1[i], 16'hA000 + 16'(i), (i == 7));
      end
      step(1'b0, 1'b0, 16'h0);
      check("j1_vo_idle", 32'(valid_out), 32'(0));
      check("j1_busy_end", 32'(busy), 32'(0));
      check("j1_done_hold", 32'(done), 32'(1));
      check("j1_addr_hold", 32'(address_out), 32'(16'h0113));

      // job 2: same job with valid_in toggling
      step(1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 16'h5A00 ^ 16'(i * 3));
         check_write($sformatf("j2_w%0d", i), exp1[i], 16'h5A00 ^ 16'(i * 3), (i == 7));
         step(1'b0, 1'b0, 16'hFFFF);
         check($sformatf("j2_gap%0d_valid", i), 32'(valid_out), 32'(0));
         check($sformatf("j2_gap%0d_addr", i), 32'(address_out), 32'(exp1[i]));
      end
      check("j2_busy_end", 32'(busy), 32'(0));

      // job 3: address wrap
      set_job(16'hFFFE, 16'd4, 16'd1, 16'h0020);
      step(1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 16'h3300 + 16'(i));
         check_write($sformatf("j3_w%0d", i), exp3[i], 16'h3300 + 16'(i), (i == 3));
      end
      check("j3_err", 32'(err), 32'(0));

      // job 4: zero-length job
      set_job(16'h0040, 16'd0, 16'd3, 16'h0001);
      step(1'b1, 1'b0, 16'h0);
      check("j4_busy", 32'(busy), 32'(0));
      check("j4_done", 32'(done), 32'(1));
      step(1'b0, 1'b1, 16'h1234);
      check("j4_valid", 32'(valid_out), 32'(0));
      check("j4_err", 32'(err), 32'(1));
      check("j4_busy2", 32'(busy), 32'(0));

      // job 5: mid-job reconfigure with colliding write
      set_job(16'h0100, 16'd4, 16'd2, 16'h0010);
      step(1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 16'h7700 + 16'(i));
         check_write($sformatf("j5_w%0d", i), exp1[i], 16'h7700 + 16'(i), 1'b0);
      end
      set_job(16'h0200, 16'd4, 16'd2, 16'h0010);
      step(1'b1, 1'b1, 16'hDEAD);
      check("j5_drop_valid", 32'(valid_out), 32'(0));
      check("j5_drop_err", 32'(err), 32'(1));
      check("j5_busy", 32'(busy), 32'(1));
      check("j5_no_done", 32'(done), 32'(0));
      step(1'b0, 1'b1, 16'h8800);
      check_write("j5_n0", 16'h0200, 16'h8800, 1'b0);
      step(1'b0, 1'b1, 16'h8801);
      check_write("j5_n1", 16'h0201, 16'h8801, 1'b0);

      // async reset while valid_out is high
      step(1'b0, 1'b1, 16'h8802);
      check_write("j6_pre", 16'h0202, 16'h8802, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("ar_valid", 32'(valid_out), 32'(0));
      check("ar_addr",  32'(address_out), 32'(0));
      check("ar_data",  32'(data_out), 32'(0));
      check("ar_busy",  32'(busy), 32'(0));
      check("ar_done",  32'(done), 32'(0));
      check("ar_err",   32'(err), 32'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      step(1'b0, 1'b0, 16'h0);
      check("post_busy", 32'(busy), 32'(0));
      check("post_done", 32'(done), 32'(0));
      step(1'b0, 1'b1, 16'h4444);
      check("post_idle_valid", 32'(valid_out), 32'(0));
      check("post_idle_err", 32'(err), 32'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/write_addr_seq.md
# write_addr_seq

Write-address sequencer between the WRITE block's output port and the block RAM write port. WRITE emits clipped groups at a fixed address. This block replaces that address with a generated sequence of `num_iters` iterations, each of `writes_per_iter` consecutive addresses, with each iteration's base advanced by `iter_stride`. It registers the write toward memory, reports busy/done, and flags writes that arrive with no active job.

## Interface

Parameters:
- GROUP_SIZE, 4, elements per write group
- OUT_DATA_WIDTH, 4, bits per element (WRITE output width)
- LOG_MAX_ADDRESS, 16, address and per-iteration counter width
- LOG_MAX_ITERS, 16, iteration counter width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- configure  in  1  single-cycle job start; samples the four fields below
- base_address  in  LOG_MAX_ADDRESS  first address of iteration 0
- writes_per_iter  in  LOG_MAX_ADDRESS  writes per iteration
- num_iters  in  LOG_MAX_ITERS  number of iterations
- iter_stride  in  LOG_MAX_ADDRESS  base increment between iterations
- data_in  in  GROUP_SIZE*OUT_DATA_WIDTH  write data from WRITE
- valid_in  in  1  write valid from WRITE; no backpressure, always accepted
- data_out  out  GROUP_SIZE*OUT_DATA_WIDTH  data to block RAM
- address_out  out  LOG_MAX_ADDRESS  address to block RAM
- valid_out  out  1  write enable to block RAM
- busy  out  1  high in RUN
- done  out  1  high in DONE until the next configure
- err  out  1  sticky; a write arrived outside RUN

## Operation

- State machine IDLE / RUN / DONE.
  - Reset enters IDLE.
  - configure in any state registers the fields, clears counters, and sets iter_base and addr to base_address.
  - The target state after configure is RUN, or DONE if writes_per_iter==0 or num_iters==0.
- RUN, valid_in=1:
  - Issue a write with address = addr and data = data_in.
  - If wcnt < writes_per_iter-1: wcnt++, addr++.
  - Otherwise (end of iteration): wcnt=0, icnt++, iter_base += iter_stride, addr = iter_base + iter_stride.
  - If this is the last write of the last iteration (icnt==num_iters-1), go to DONE.
- RUN, valid_in=0: hold all state.
- IDLE or DONE, valid_in=1 without configure: drop the write (no valid_out) and set err.
- configure and valid_in in the same cycle:
  - configure wins.
  - The incoming write is dropped and sets err, in every state.
  - An in-flight job is aborted with no done.
- Arithmetic is modulo 2^LOG_MAX_ADDRESS. Address and iter_base wrap silently, with no error.
- err clears only on reset.

## Timing

- Latency is 1 cycle: a write accepted at cycle t appears on data_out/address_out/valid_out at t+1.
- valid_out is high for exactly one cycle per accepted write. Back-to-back writes are sustained at 1 per cycle with no bubble at iteration boundaries.
- data_out and address_out hold their last value when valid_out=0.
- busy follows state: RUN is visible the cycle after configure.
- done rises the cycle after the final accepted write, coincident with that write's valid_out. For zero-length jobs it rises the cycle after configure.
- Reset values: data_out=0, address_out=0, valid_out=0, busy=0, done=0, err=0; counters 0.
- Asynchronous reset mid-job: outputs are cleared immediately and the pending registered write is discarded.

## Test plan

- configure base=0x0100, wpi=4, iters=2, stride=0x0010; 8 consecutive valid_in -> addresses 0x0100–0x0103, 0x0110–0x0113; done with the 8th valid_out; busy low thereafter.
- Same job with valid_in toggling 1/0 -> identical address sequence; data_out matches data_in one cycle later; done after the 8th write.
- base=0xFFFE, wpi=4, iters=1 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; err stays 0.
- wpi=0 -> done the cycle after configure, busy never 1; a following valid_in gives no valid_out and err=1.
- Mid-job configure base=0x0200 after 3 writes, with valid_in in the same cycle -> that write dropped, err=1, next writes start at 0x0200, no done for the first job.
- Assert rst low while valid_out=1 -> all outputs 0 immediately; state IDLE after release.
